ascon_perm_ctrl_2rc: RTL

- Round-sequencing controller for the 2-rounds-per-cycle unrolled ASCON permutation.
- Sits directly upstream of the round-constant generator and drives its load/increment controls: init flag, increment flag, 4-bit start index.
- Also drives the state-register load and round-enable strobes of the unrolled datapath.
- Handles p^a (12 rounds) and p^b (6 or 8 rounds) with a start/done handshake toward the AEAD mode FSM.

---
 rtl/ascon_perm_ctrl_2rc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ascon_perm_ctrl_2rc.sv
// Round sequencer for the 2-rounds-per-cycle ASCON permutation.
// It drives the round-constant generator and the datapath strobes. Optional macro: ASCON_PERM_ERR_EN (reject rounds_sel=11 with a sticky err).
module ascon_perm_ctrl_2rc #(
    parameter int ROUNDS_A  = 12,
    parameter int ROUNDS_B6 = 6,
    parameter int ROUNDS_B8 = 8,
    parameter int UNROLL    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] rounds_sel,
    output logic       ready,
    output logic       busy,
    output logic       rc_init,
    output logic       rc_inc,
    output logic [3:0] rc_consti,
    output logic       state_ld,
    output logic       round_en,
    output logic       last_rnd,
    output logic [2:0] rnd_cnt,
    output logic       done
`ifdef ASCON_PERM_ERR_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [2:0] CNT_A    = 3'(ROUNDS_A / UNROLL);
    localparam logic [2:0] CNT_B6   = 3'(ROUNDS_B6 / UNROLL);
    localparam logic [2:0] CNT_B8   = 3'(ROUNDS_B8 / UNROLL);
    localparam logic [3:0] CONST_A  = 4'(12 - ROUNDS_A);
    localparam logic [3:0] CONST_B6 = 4'(12 - ROUNDS_B6);
    localparam logic [3:0] CONST_B8 = 4'(12 - ROUNDS_B8);

    state_t     state_reg;
    logic [1:0] sel_reg;
    logic       ready_reg;
    logic       busy_reg;
    logic       rc_init_reg;
    logic       rc_inc_reg;
    logic [3:0] rc_consti_reg;
    logic       state_ld_reg;
    logic       round_en_reg;
    logic       last_rnd_reg;
    logic [2:0] rnd_cnt_reg;
    logic       done_reg;
`ifdef ASCON_PERM_ERR_EN
    logic       err_reg;
`endif

    // Encoding 11 (and anything unknown) falls back to the full 12-round p^a.
    function automatic logic [2:0] cycles_for(input logic [1:0] sel);
        case (sel)
            2'b01:   cycles_for = CNT_B8;
            2'b10:   cycles_for = CNT_B6;
            default: cycles_for = CNT_A;
        endcase
    endfunction

    function automatic logic [3:0] consti_for(input logic [1:0] sel);
        case (sel)
            2'b01:   consti_for = CONST_B8;
            2'b10:   consti_for = CONST_B6;
            default: consti_for = CONST_A;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sel_reg       <= 2'b00;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            rc_init_reg   <= 1'b0;
            rc_inc_reg    <= 1'b0;
            rc_consti_reg <= 4'd0;
            state_ld_reg  <= 1'b0;
            round_en_reg  <= 1'b0;
            last_rnd_reg  <= 1'b0;
            rnd_cnt_reg   <= 3'd0;
            done_reg      <= 1'b0;
`ifdef ASCON_PERM_ERR_EN
            err_reg       <= 1'b0;
`endif
        end else begin
            rc_init_reg  <= 1'b0;
            rc_inc_reg   <= 1'b0;
            state_ld_reg <= 1'b0;
            round_en_reg <= 1'b0;
            last_rnd_reg <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // ready_reg is low while err is set, so no start gets through then.
                    if (start && ready_reg) begin
`ifdef ASCON_PERM_ERR_EN
                        if (rounds_sel == 2'b11) begin
                            err_reg   <= 1'b1;
                            ready_reg <= 1'b0;
                        end else
`endif
                        begin
                            sel_reg       <= rounds_sel;
                            rc_consti_reg <= consti_for(rounds_sel);
                            state_reg     <= LOAD;
                            ready_reg     <= 1'b0;
                            busy_reg      <= 1'b1;
                            rc_init_reg   <= 1'b1;
                            state_ld_reg  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state_reg    <= RUN;
                    rnd_cnt_reg  <= cycles_for(sel_reg);
                    round_en_reg <= 1'b1;
                    rc_inc_reg   <= (cycles_for(sel_reg) > 3'd1);
                    last_rnd_reg <= (cycles_for(sel_reg) == 3'd1);
                end
                RUN: begin
                    if (rnd_cnt_reg <= 3'd1) begin
                        state_reg   <= DONE;
                        rnd_cnt_reg <= 3'd0;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                    end else begin
                        // The final cycle holds the generator on the last constant pair.
                        rnd_cnt_reg  <= rnd_cnt_reg - 3'd1;
                        round_en_reg <= 1'b1;
                        rc_inc_reg   <= (rnd_cnt_reg > 3'd2);
                        last_rnd_reg <= (rnd_cnt_reg == 3'd2);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready     = ready_reg;
    assign busy      = busy_reg;
    assign rc_init   = rc_init_reg;
    assign rc_inc    = rc_inc_reg;
    assign rc_consti = rc_consti_reg;
    assign state_ld  = state_ld_reg;
    assign round_en  = round_en_reg;
    assign last_rnd  = last_rnd_reg;
    assign rnd_cnt   = rnd_cnt_reg;
    assign done      = done_reg;
`ifdef ASCON_PERM_ERR_EN
    assign err       = err_reg;
`endif

endmodule
